// File: rtl/xm23_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xm23_pkg
//  Description : Shared types, register indices, constant-bank table and
//                byte-merge helper for the XM23 write-back path.
//  Revision    : 1.0  initial release
// ============================================================================
package xm23_pkg;

    // One register-file write request as presented by a producer
    typedef struct packed {
        logic        we;
        logic [2:0]  dst;
        logic [15:0] data;
        logic        byte_mode;
    } wb_req_t;

    // Architectural aliases within R0-R7
    localparam int REG_LR = 5;
    localparam int REG_SP = 6;
    localparam int REG_PC = 7;

    // Bank 1 operand constants, index 7 in the MSB slot
    localparam logic [7:0][15:0] CONST_TABLE = {
        16'hFFFF, 16'h0020, 16'h0010, 16'h0008,
        16'h0004, 16'h0002, 16'h0001, 16'h0000
    };

    // Byte mode replaces only the low lane and keeps the old high lane
    function automatic logic [15:0] merge_byte(
        input logic [15:0] old_val,
        input logic [15:0] new_val,
        input logic        byte_mode
    );
        merge_byte = byte_mode ? {old_val[15:8], new_val[7:0]} : new_val;
    endfunction

endpackage : xm23_pkg
`default_nettype wire

// File: rtl/wb_pend_buf.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pend_buf
//  Description : One-entry holding register for a deferred write-back
//                request, with load/drain controls and a valid flag.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_pend_buf
    import xm23_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_load,
    input  logic    i_drain,
    input  wb_req_t i_req,
    output logic    o_valid,
    output wb_req_t o_req
);

    logic    r_valid;
    wb_req_t r_req;

    // Capture on load, release on drain; load takes precedence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_req   <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_req   <= i_req;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_req   = r_req;

endmodule : wb_pend_buf
`default_nettype wire

// File: rtl/gprc_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : gprc_writeback
//  Description : R0-R7 register file with a single write slot shared by the
//                execute and load ports, a one-entry collision buffer that
//                stalls producers, and a fetch-path PC update on R[PC_IDX].
//                Publishes GPRs (bank 0) and constants (bank 1).
//  Revision    : 1.0  initial release
// ============================================================================
module gprc_writeback
    import xm23_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                PC_IDX   = REG_PC,
    parameter logic [DATA_W-1:0] PC_RESET = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ex_we,
    input  logic [2:0]                    ex_dst,
    input  logic [DATA_W-1:0]             ex_data,
    input  logic                          ex_byte,
    input  logic                          ld_we,
    input  logic [2:0]                    ld_dst,
    input  logic [DATA_W-1:0]             ld_data,
    input  logic                          ld_byte,
    input  logic                          pc_we,
    input  logic [DATA_W-1:0]             pc_next,
    output logic [1:0][7:0][DATA_W-1:0]   gprc,
    output logic                          stall
);

    logic [7:0][DATA_W-1:0] r_gpr;

    wb_req_t w_ex_req;
    wb_req_t w_ld_req;
    wb_req_t w_commit;
    wb_req_t w_pend_req;
    logic    w_pend_valid;
    logic    w_pend_load;
    logic    w_pend_drain;

    assign w_ex_req = '{we: ex_we, dst: ex_dst, data: ex_data, byte_mode: ex_byte};
    assign w_ld_req = '{we: ld_we, dst: ld_dst, data: ld_data, byte_mode: ld_byte};

    wb_pend_buf u_pend (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_pend_load),
        .i_drain (w_pend_drain),
        .i_req   (w_ld_req),
        .o_valid (w_pend_valid),
        .o_req   (w_pend_req)
    );

    // Slot arbitration: pending entry first, then execute, then load
    always_comb begin
        w_commit     = '0;
        w_pend_load  = 1'b0;
        w_pend_drain = 1'b0;
        if (w_pend_valid) begin
            // Producers are stalled, so their requests are ignored this cycle
            w_commit     = w_pend_req;
            w_pend_drain = 1'b1;
        end else if (ex_we) begin
            w_commit    = w_ex_req;
            w_pend_load = ld_we;
        end else if (ld_we) begin
            w_commit = w_ld_req;
        end
    end

    // Register file: GPR commit beats the fetch-path PC update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                r_gpr[i] <= (i == PC_IDX) ? PC_RESET : '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (w_commit.we && (int'(w_commit.dst) == i)) begin
                    r_gpr[i] <= merge_byte(r_gpr[i], w_commit.data, w_commit.byte_mode);
                end else if (pc_we && (i == PC_IDX)) begin
                    r_gpr[i] <= pc_next;
                end
            end
        end
    end

    assign gprc[0] = r_gpr;
    assign gprc[1] = CONST_TABLE;
    assign stall   = w_pend_valid;

endmodule : gprc_writeback
`default_nettype wire

// File: tb/tb_gprc_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gprc_writeback
//  Description : Self-checking bench for gprc_writeback: directed scenarios
//                plus randomized traffic against a queue-based model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gprc_writeback;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   ex_we = 1'b0;
    logic [2:0]             ex_dst = '0;
    logic [15:0]            ex_data = '0;
    logic                   ex_byte = 1'b0;
    logic                   ld_we = 1'b0;
    logic [2:0]             ld_dst = '0;
    logic [15:0]            ld_data = '0;
    logic                   ld_byte = 1'b0;
    logic                   pc_we = 1'b0;
    logic [15:0]            pc_next = '0;
    logic [1:0][7:0][15:0]  gprc;
    logic                   stall;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [15:0] PC_RST = 16'h0000;

    gprc_writeback #(.DATA_W(16), .PC_IDX(7), .PC_RESET(PC_RST)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ex_we   (ex_we),
        .ex_dst  (ex_dst),
        .ex_data (ex_data),
        .ex_byte (ex_byte),
        .ld_we   (ld_we),
        .ld_dst  (ld_dst),
        .ld_data (ld_data),
        .ld_byte (ld_byte),
        .pc_we   (pc_we),
        .pc_next (pc_next),
        .gprc    (gprc),
        .stall   (stall)
    );

    always #5 clk = ~clk;

    // Reference model: register values plus a queue of deferred writes
    typedef struct {
        logic [2:0]  dst;
        logic [15:0] data;
        logic        bm;
    } req_t;

    logic [15:0] m_reg [8];
    req_t        pq [$];
    logic [15:0] const_exp [8] = '{16'h0000, 16'h0001, 16'h0002, 16'h0004,
                                   16'h0008, 16'h0010, 16'h0020, 16'hFFFF};

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
        m_reg[7] = PC_RST;
        pq.delete();
    endtask

    // Applies one clock edge worth of write-back to the model
    task automatic model_edge();
        req_t c;
        bit   have = 0;
        req_t e = '{ex_dst, ex_data, ex_byte};
        req_t l = '{ld_dst, ld_data, ld_byte};
        if (pq.size() > 0) begin
            c = pq.pop_front();
            have = 1;
        end else if (ex_we) begin
            c = e;
            have = 1;
            if (ld_we) pq.push_back(l);
        end else if (ld_we) begin
            c = l;
            have = 1;
        end
        if (have) m_reg[c.dst] = c.bm ? {m_reg[c.dst][15:8], c.data[7:0]} : c.data;
        if (pc_we && !(have && c.dst == 3'd7)) m_reg[7] = pc_next;
    endtask

    task automatic idle();
        ex_we = 0; ld_we = 0; pc_we = 0;
        ex_byte = 0; ld_byte = 0;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [2:0] d, input logic [15:0] v, input logic b);
        ex_we = 1; ex_dst = d; ex_data = v; ex_byte = b;
    endtask

    task automatic set_ld(input logic [2:0] d, input logic [15:0] v, input logic b);
        ld_we = 1; ld_dst = d; ld_data = v; ld_byte = b;
    endtask

    task automatic assert_reset();
        rst_n = 0;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        rst_n = 1;
        #1;
    endtask

    task automatic test_reset();
        // Dirty every register first so reset has something to clear
        for (int i = 0; i < 8; i++) begin
            idle();
            set_ex(3'(i), 16'hA500 + 16'(i), 0);
            cycle();
        end
        idle();
        assert_reset();
        for (int i = 0; i < 8; i++) begin
            logic [15:0] exp = (i == 7) ? PC_RST : 16'h0000;
            n_tests++;
            if (gprc[0][i] !== exp) begin
                n_fail++;
                $display("FAIL reset_r%0d got=%h exp=%h", i, gprc[0][i], exp);
            end
            n_tests++;
            if (gprc[1][i] !== const_exp[i]) begin
                n_fail++;
                $display("FAIL const_%0d got=%h exp=%h", i, gprc[1][i], const_exp[i]);
            end
        end
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stall got=%b exp=0", stall);
        end
        release_reset();
    endtask

    task automatic test_byte_write();
        idle(); set_ex(3'd3, 16'hABCD, 0); cycle();
        idle(); set_ex(3'd3, 16'h1234, 1); cycle();
        n_tests++;
        if (gprc[0][3] !== 16'hAB34) begin
            n_fail++;
            $display("FAIL byte_write got=%h exp=AB34", gprc[0][3]);
        end
        idle(); set_ex(3'd3, 16'h1234, 0); cycle();
        n_tests++;
        if (gprc[0][3] !== 16'h1234) begin
            n_fail++;
            $display("FAIL word_write got=%h exp=1234", gprc[0][3]);
        end
        idle(); set_ld(3'd3, 16'hFF77, 1); cycle();
        n_tests++;
        if (gprc[0][3] !== 16'h1277) begin
            n_fail++;
            $display("FAIL ld_byte_write got=%h exp=1277", gprc[0][3]);
        end
        idle();
    endtask

    task automatic test_collision();
        idle();
        set_ex(3'd1, 16'h1111, 0);
        set_ld(3'd2, 16'h2222, 0);
        cycle();
        n_tests++;
        if (gprc[0][1] !== 16'h1111 || stall !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_n r1=%h stall=%b exp r1=1111 stall=1", gprc[0][1], stall);
        end
        // Different values presented during the stall must be ignored
        set_ex(3'd1, 16'hDEAD, 0);
        set_ld(3'd2, 16'hBEEF, 0);
        cycle();
        idle();
        n_tests++;
        if (gprc[0][2] !== 16'h2222 || stall !== 1'b0 || gprc[0][1] !== 16'h1111) begin
            n_fail++;
            $display("FAIL collision_n1 r1=%h r2=%h stall=%b exp r1=1111 r2=2222 stall=0",
                     gprc[0][1], gprc[0][2], stall);
        end
    endtask

    task automatic test_same_dst();
        idle();
        set_ex(3'd4, 16'h00AA, 0);
        set_ld(3'd4, 16'h5555, 0);
        cycle();
        idle();
        n_tests++;
        if (gprc[0][4] !== 16'h00AA) begin
            n_fail++;
            $display("FAIL same_dst_n got=%h exp=00AA", gprc[0][4]);
        end
        cycle();
        n_tests++;
        if (gprc[0][4] !== 16'h5555) begin
            n_fail++;
            $display("FAIL same_dst_n1 got=%h exp=5555", gprc[0][4]);
        end
    endtask

    task automatic test_pc_conflict();
        idle();
        pc_we = 1; pc_next = 16'h0102;
        set_ex(3'd7, 16'h0400, 0);
        cycle();
        n_tests++;
        if (gprc[0][7] !== 16'h0400) begin
            n_fail++;
            $display("FAIL pc_conflict got=%h exp=0400", gprc[0][7]);
        end
        idle();
        pc_we = 1; pc_next = 16'h0402;
        cycle();
        n_tests++;
        if (gprc[0][7] !== 16'h0402) begin
            n_fail++;
            $display("FAIL pc_update got=%h exp=0402", gprc[0][7]);
        end
        // Pending write to PC beats pc_we in its drain cycle
        idle();
        set_ex(3'd0, 16'h0BAD, 0);
        set_ld(3'd7, 16'h0800, 0);
        pc_we = 1; pc_next = 16'h0404;
        cycle();
        n_tests++;
        if (gprc[0][7] !== 16'h0404) begin
            n_fail++;
            $display("FAIL pc_during_collision got=%h exp=0404", gprc[0][7]);
        end
        pc_next = 16'h0406;
        cycle();
        idle();
        n_tests++;
        if (gprc[0][7] !== 16'h0800) begin
            n_fail++;
            $display("FAIL pend_beats_pc got=%h exp=0800", gprc[0][7]);
        end
    endtask

    task automatic test_reset_during_stall();
        idle();
        set_ex(3'd5, 16'h5A5A, 0);
        set_ld(3'd2, 16'h7777, 0);
        cycle();
        n_tests++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_stall_pre got=%b exp=1", stall);
        end
        idle();
        assert_reset();
        n_tests++;
        if (stall !== 1'b0 || gprc[0][5] !== 16'h0000) begin
            n_fail++;
            $display("FAIL rst_stall_async stall=%b r5=%h exp stall=0 r5=0000", stall, gprc[0][5]);
        end
        release_reset();
        cycle();
        n_tests++;
        if (gprc[0][2] !== 16'h0000 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_stall_lost r2=%h stall=%b exp r2=0000 stall=0", gprc[0][2], stall);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            ex_we   = ($urandom_range(0, 1) == 1);
            ex_dst  = 3'($urandom_range(0, 7));
            ex_data = 16'($urandom);
            ex_byte = ($urandom_range(0, 3) == 0);
            ld_we   = ($urandom_range(0, 1) == 1);
            ld_dst  = 3'($urandom_range(0, 7));
            ld_data = 16'($urandom);
            ld_byte = ($urandom_range(0, 3) == 0);
            pc_we   = ($urandom_range(0, 3) == 0);
            pc_next = 16'($urandom);
            cycle();
            for (int i = 0; i < 8; i++) begin
                n_tests++;
                if (gprc[0][i] !== m_reg[i]) begin
                    n_fail++;
                    $display("FAIL rand_r%0d cyc=%0d got=%h exp=%h", i, n, gprc[0][i], m_reg[i]);
                end
            end
            n_tests++;
            if (stall !== (pq.size() != 0)) begin
                n_fail++;
                $display("FAIL rand_stall cyc=%0d got=%b exp=%b", n, stall, pq.size() != 0);
            end
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        model_reset();
        rst_n = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        release_reset();
        test_reset();
        test_byte_write();
        test_collision();
        test_same_dst();
        test_pc_conflict();
        test_reset_during_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_gprc_writeback
`default_nettype wire

// File: doc/gprc_writeback.md
Name: gprc_writeback

Overview:
- Register-file owner and write-back end of the execute path: accepts results produced by the move/ALU units (execute port) and by memory loads (load port), and commits them into R0–R7.
- Publishes the two-bank operand array consumed by the execute units: bank 0 is the GPRs, bank 1 is the constant table.
- Single register-file write slot per cycle. A one-entry pending buffer absorbs execute/load collisions and drives a stall back to the producers.
- R7 doubles as PC and is also updated from the fetch path.

Parameters:
- DATA_W, 16, register width; byte lane is DATA_W/2.
- PC_IDX, 7, register index aliased as program counter.
- PC_RESET, 16'h0000, reset value of R[PC_IDX].

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_we  in  1  execute-port write request.
- ex_dst  in  3  execute-port destination register.
- ex_data  in  16  execute-port data.
- ex_byte  in  1  1 = write low byte only, preserve high byte.
- ld_we  in  1  load-port write request.
- ld_dst  in  3  load-port destination.
- ld_data  in  16  load-port data.
- ld_byte  in  1  load byte-mode flag, same rule as ex_byte.
- pc_we  in  1  fetch PC update request.
- pc_next  in  16  next PC value.
- gprc  out  [1:0][7:0][15:0]  bank 0 = R0–R7 (registered), bank 1 = constants.
- stall  out  1  write slot busy; producers hold and re-present.

Behaviour:
- Reset (async, rst_n=0):
  - R0–R6 = 0; R[PC_IDX] = PC_RESET.
  - Pending buffer invalid; stall = 0.
  - Bank 1 is constant in all states: {0, 1, 2, 4, 8, 16, 32, 16'hFFFF} for indices 0–7.
- Commit rule for a request (dst, data, byte) in one cycle:
  - byte=0: R[dst] <= data.
  - byte=1: R[dst] <= {R[dst][15:8], data[7:0]}.
  - R[dst] is the register value at the start of that cycle.
- Latency: a commit at edge N is visible on gprc after edge N. There is no combinational bypass; forwarding is the pipeline's job.
- stall = pend_valid (registered, glitch-free). While stall=1, ex_we and ld_we are ignored; the producers keep their requests asserted.
- Slot arbitration each cycle, in priority order:
  - pend_valid=1: commit the pending entry; pend_valid <= 0.
  - Otherwise, ex_we and ld_we both set: commit ex; capture ld into pending; pend_valid <= 1.
  - Otherwise, only one of ex_we or ld_we set: commit it.
  - Otherwise: no GPR write.
- Same-destination collision (ex_dst == ld_dst): ex commits at edge N, ld at edge N+1. The final value is the load's; both byte modes are honoured in that order.
- PC port: if pc_we=1 and no GPR commit targets PC_IDX this cycle, R[PC_IDX] <= pc_next. A GPR commit to PC_IDX wins and pc_next is dropped. pc_we is not blocked by stall.
- Pending entry targeting PC_IDX: it beats pc_we in its commit cycle.
- Reset mid-operation: the pending entry is discarded, stall drops immediately (async), and all registers return to reset values.
- No X on outputs after reset; all dst indices 0–7 are legal.

Decomposition:
- Shared package xm23_pkg:
  - wb_req_t struct {we, dst[2:0], data[15:0], byte_mode}.
  - localparams REG_LR=5, REG_SP=6, REG_PC=7.
  - CONST_TABLE[8] for bank 1.
  - Byte-merge function merge_byte(old, new, byte_mode).
- One natural sub-module: wb_pend_buf, a one-entry wb_req_t holding register with load/drain controls and a valid flag. The register array and arbitration stay in gprc_writeback.

Test Plan:
- Reset: rst_n=0 mid-run → gprc[0][0..6]=0, gprc[0][7]=PC_RESET, stall=0; gprc[1] = {0,1,2,4,8,16,32,FFFF} throughout.
- Byte write: R3=16'hABCD; ex_we, ex_dst=3, ex_data=16'h1234, ex_byte=1 → next cycle R3=16'hAB34. Repeat with ex_byte=0 → R3=16'h1234.
- Collision:
  - Same cycle ex(R1 ← 16'h1111) and ld(R2 ← 16'h2222) → after edge N: R1=16'h1111, stall=1.
  - Inputs ignored during stall → after edge N+1: R2=16'h2222, stall=0.
- Same destination: ex(R4 ← 16'h00AA) and ld(R4 ← 16'h5555) together → R4=16'h00AA after N, R4=16'h5555 after N+1.
- PC conflict: pc_we=1, pc_next=16'h0102 with ex(R7 ← 16'h0400) → R7=16'h0400. Next cycle, pc_we only, pc_next=16'h0402 → R7=16'h0402.
- Reset during stall: collision, then rst_n=0 before drain → pending entry lost, stall=0, target register=0 after release.
